// File: rtl/conv_serializer_nx.sv
// conv_serializer_nx: parallel-to-serial converter with a one-word holding register for gapless
// back-to-back words, and an optional DDR mode that sends two bits per clock.
module conv_serializer_nx #(
    parameter int   WIDTH     = 8,
    parameter bit   DDR       = 1'b0,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PAR_IN,
    input  logic             PAR_VALID,
    output logic             PAR_READY,
    output logic             SERIAL_OUT,
    output logic             SERIAL_VALID,
    output logic             FRAME_START,
    output logic             BUSY
);
    localparam int B    = DDR ? WIDTH / 2 : WIDTH;
    localparam int CW   = B > 1 ? $clog2(B) : 1;
    localparam int STEP = DDR ? 2 : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, hold, hold_nx, par_ord;
    logic             hold_full, hold_full_nx, xfer, last;

    // Words are stored in send order so the shifter always emits from bit 0 (and bit 1 in DDR).
    function automatic logic [WIDTH-1:0] to_send_order(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
        return r;
    endfunction

    assign par_ord = to_send_order(PAR_IN);

    always_comb begin
        xfer         = PAR_VALID && !hold_full;
        last         = state == SHIFT && cnt == CW'(B - 1);
        state_nx     = state;
        cnt_nx       = cnt;
        shreg_nx     = shreg;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        if (state == SHIFT) begin
            cnt_nx   = cnt + 1'b1;
            shreg_nx = shreg >> STEP;
        end
        if (last) begin
            cnt_nx = '0;
            if (hold_full) begin
                shreg_nx     = hold;
                hold_full_nx = 1'b0;
            end else if (!xfer) begin
                state_nx = IDLE;
            end
        end
        if (xfer) begin
            if (state == IDLE || last) begin
                shreg_nx = par_ord;
                cnt_nx   = '0;
                state_nx = SHIFT;
            end else begin
                hold_nx      = par_ord;
                hold_full_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
        end
    end

    assign PAR_READY    = !hold_full;
    assign SERIAL_VALID = state == SHIFT;
    assign FRAME_START  = SERIAL_VALID && cnt == '0;
    assign BUSY         = SERIAL_VALID || hold_full;
    // In DDR the high phase shows the earlier bit, the low phase the later one; both are flop outputs.
    assign SERIAL_OUT   = !SERIAL_VALID ? IDLE_VAL : (DDR && !CLK) ? shreg[1] : shreg[0];
endmodule

// File: tb/tb_conv_serializer_nx.sv
// tb_conv_serializer_nx: several serializer configurations driven with directed and random words,
// checked by a word-schedule reference model and a beat scoreboard.
module tb_conv_serializer_nx;
    localparam int NI = 5;
    localparam int WP [NI] = '{8, 8, 5, 8, 2};
    localparam int DP [NI] = '{0, 1, 0, 1, 1};
    localparam int MP [NI] = '{0, 1, 1, 0, 0};
    localparam int IP [NI] = '{0, 1, 0, 0, 1};

    typedef struct packed {logic hi; logic lo;} beat_t;

    logic clk, rst, go, mid;
    int   checks = 0, errors = 0, ndone = 0;

    task automatic chk(input string nm, input int g, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %b, want %b", nm, g, $time, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int   W  = WP[g];
        localparam int   B  = DP[g] != 0 ? W / 2 : W;
        localparam logic IV = IP[g] != 0;

        logic [7:0] pin;
        logic       pv, rdy, so, sv, fs, bsy;

        conv_serializer_nx #(
            .WIDTH(W), .DDR(DP[g] != 0), .MSB_FIRST(MP[g] != 0), .IDLE_VAL(IV)
        ) dut (
            .CLK(clk), .RESET(rst), .PAR_IN(pin[W-1:0]), .PAR_VALID(pv),
            .PAR_READY(rdy), .SERIAL_OUT(so), .SERIAL_VALID(sv), .FRAME_START(fs), .BUSY(bsy)
        );

        // Reference: a word accepted at edge e occupies beat slots [max(e, end_of_previous), +B).
        beat_t      bq[$];
        int         st[$];
        int         e = 0, pend_end = 0;
        logic       hs = 1'b0, cur_ok = 1'b0, ev, hexp, fexp;
        logic [7:0] hw;
        beat_t      cur;

        function automatic logic ord(input logic [7:0] w, input int i);
            return MP[g] != 0 ? w[W-1-i] : w[i];
        endfunction

        task automatic push_word(input logic [7:0] w);
            int s;
            beat_t bt;
            s = e > pend_end ? e : pend_end;
            st.push_back(s);
            pend_end = s + B;
            for (int j = 0; j < B; j++) begin
                bt.hi = ord(w, DP[g] != 0 ? 2 * j : j);
                bt.lo = ord(w, DP[g] != 0 ? 2 * j + 1 : j);
                bq.push_back(bt);
            end
        endtask

        task automatic chk_reset();
            chk("rst_ready", g, rdy, 1'b1);
            chk("rst_valid", g, sv, 1'b0);
            chk("rst_frame", g, fs, 1'b0);
            chk("rst_busy", g, bsy, 1'b0);
            chk("rst_out", g, so, IV);
        endtask

        always @(negedge rst) begin
            #1;
            chk_reset();
        end

        always @(posedge clk) begin
            #1;
            e++;
            if (!rst) begin
                bq.delete();
                st.delete();
                pend_end = 0;
                hs = 1'b0;
                cur_ok = 1'b0;
                chk_reset();
            end else begin
                if (hs) push_word(hw);
                hs = 1'b0;
                while (st.size() > 0 && st[0] + B <= e) void'(st.pop_front());
                ev   = st.size() > 0 && st[0] <= e;
                fexp = ev && st[0] == e;
                hexp = st.size() > 0 && st[st.size()-1] > e;
                chk("valid", g, sv, ev);
                chk("frame", g, fs, fexp);
                chk("ready", g, rdy, !hexp);
                chk("busy", g, bsy, ev || hexp);
                cur_ok = 1'b0;
                if (sv) begin
                    if (bq.size() == 0) chk("beat_underflow", g, 1'b1, 1'b0);
                    else begin
                        cur = bq.pop_front();
                        cur_ok = 1'b1;
                        chk("out_hi", g, so, cur.hi);
                    end
                end else chk("idle_hi", g, so, IV);
            end
        end

        always @(negedge clk) begin
            #1;
            if (!rst) begin
                hs = 1'b0;
                chk("rst_out_lo", g, so, IV);
            end else begin
                if (sv && cur_ok) chk("out_lo", g, so, cur.lo);
                else if (!sv) chk("idle_lo", g, so, IV);
                hs = pv && rdy;
                hw = pin;
            end
        end

        task automatic offer(input logic [7:0] w);
            pin = w;
            pv  = 1'b1;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (rdy) begin
                    @(posedge clk);
                    #2;
                    return;
                end
            end
            chk("accept_timeout", g, 1'b0, 1'b1);
        endtask

        task automatic idle(input int n);
            pv = 1'b0;
            repeat (n) @(posedge clk);
            #2;
        endtask

        initial begin
            pv  = 1'b0;
            pin = '0;
            wait (go);
            @(posedge clk);
            #2;
            offer(8'hC1);
            idle(B + 3);
            offer(8'h0F);
            offer(8'hF0);
            idle(2 * B + 2);
            offer(8'hA5);
            offer(8'h3C);
            offer(8'h96);
            idle(3 * B + 2);
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, B + 2)));
                offer(8'($urandom));
            end
            idle(2 * B + 4);
            ndone++;
            if (g == 0) begin
                wait (ndone == NI);
                @(posedge clk);
                #2;
                offer(8'hC1);
                pv = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                mid = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        mid = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        go  = 1'b1;
        wait (mid);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_serializer_nx.md
CONV_SERIALIZER_NX -- requirements
Module: conv_serializer_nx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: parallel word width in bits; legal values are 2 or more, and must be even when DDR=1.
REQ-002 SHALL provide parameter DDR, default 0: 0 sends one bit per CLK cycle; 1 sends two bits per cycle, one on each CLK phase.
REQ-003 SHALL provide parameter MSB_FIRST, default 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.
REQ-004 SHALL provide parameter IDLE_VAL, default 1'b0: SERIAL_OUT level whenever no word is being sent.
REQ-005 SHALL provide port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port RESET, input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
REQ-007 SHALL provide port PAR_IN, input, WIDTH bits: parallel word to serialize.
REQ-008 SHALL provide port PAR_VALID, input, 1 bit: PAR_IN holds a word.
REQ-009 SHALL provide port PAR_READY, output, 1 bit: the block can accept a word this cycle.
REQ-010 SHALL provide port SERIAL_OUT, output, 1 bit: serial data.
REQ-011 SHALL provide port SERIAL_VALID, output, 1 bit: SERIAL_OUT carries word data this cycle.
REQ-012 SHALL provide port FRAME_START, output, 1 bit: the current beat is the first beat of a word.
REQ-013 SHALL provide port BUSY, output, 1 bit: the shifter or the holding register is occupied.

Function
REQ-014 SHALL transfer a word only at a rising edge where PAR_VALID=1 and PAR_READY=1; PAR_IN is sampled at that edge.
REQ-015 SHALL define B = WIDTH beats per word when DDR=0, and B = WIDTH/2 when DDR=1.
REQ-016 SHALL contain a shift register, a beat counter (0..B-1) and a one-word holding register.
REQ-017 SHALL implement the FSM with states IDLE and SHIFT:
- IDLE to SHIFT on a transfer.
- SHIFT to IDLE at the last-beat edge when the holding register is empty and no transfer occurs.
- Otherwise remain in SHIFT.
REQ-018 SHALL drive PAR_READY = NOT(holding register full), from registered state only, with no combinational path from PAR_VALID.
REQ-019 SHALL route a transferred word as follows:
- If the FSM is in IDLE, or in SHIFT on the last beat, and the holding register is empty: load the shifter directly and reset the counter to 0.
- Otherwise: write the word into the holding register.
REQ-020 SHALL, at a last-beat edge with the holding register full, move the holding word into the shifter and clear the holding register, so consecutive words leave no gap beat.
REQ-021 SHALL present the first beat in the cycle after the load edge, giving a latency of 1 cycle from transfer to first beat when the FSM is in IDLE.
REQ-022 SHALL, when DDR=0, drive SERIAL_OUT with bit k of the word during beat k, where bit order follows MSB_FIRST.
REQ-023 SHALL, when DDR=1, drive SERIAL_OUT during beat j as follows:
- While CLK=1: bit 2j of the word in send order.
- While CLK=0: bit 2j+1 of the word in send order.
- The output SHALL be a glitch-free mux on CLK level between two registered bits.
REQ-024 SHALL drive SERIAL_VALID=1 in SHIFT and 0 in IDLE; SERIAL_OUT=IDLE_VAL whenever SERIAL_VALID=0, on both CLK phases.
REQ-025 SHALL drive FRAME_START=1 exactly when SERIAL_VALID=1 and the counter is 0.
REQ-026 SHALL drive BUSY = (state==SHIFT) OR (holding register full).
REQ-027 SHALL hold its state unchanged, with no transfer, when PAR_VALID=1 while PAR_READY=0; PAR_IN is ignored in that case.
REQ-028 SHALL keep the counter from wrapping except through a load at the last beat; the counter holds 0 in IDLE.

Reset
REQ-029 SHALL, while RESET=0, asynchronously force the following, with the outputs taking these values while RESET=0 regardless of CLK:
- State IDLE, counter 0, holding register empty, shift register 0.
- PAR_READY=1, SERIAL_VALID=0, FRAME_START=0, BUSY=0, SERIAL_OUT=IDLE_VAL.
REQ-030 SHALL discard any partially sent word and any held word when reset is asserted mid-word; no data resumes after release.
REQ-031 SHALL act on its first possible transfer at the first rising edge after RESET rises.

Verification
REQ-032 SHALL pass this single-word test: WIDTH=8, DDR=0, MSB_FIRST=0, transfer 0xC1 from IDLE -> the next 8 cycles show SERIAL_OUT=1,0,0,0,0,0,1,1; FRAME_START=1 in cycle 1 only; then IDLE with SERIAL_OUT=0.
REQ-033 SHALL pass this bit-order test: MSB_FIRST=1, transfer 0xC1 -> SERIAL_OUT=1,1,0,0,0,0,0,1.
REQ-034 SHALL pass this back-to-back test: PAR_VALID held at 1 with 0x0F then 0xF0 -> 16 consecutive valid beats 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; FRAME_START on beats 1 and 9; no gap beat.
REQ-035 SHALL pass this backpressure test: three words offered on consecutive cycles -> word 3 waits with PAR_READY=0 until the edge where word 1 finishes, and PAR_IN is held stable until it is accepted.
REQ-036 SHALL pass this DDR test: DDR=1, WIDTH=8, 0xC1 LSB-first -> four beats showing (high,low) pairs (1,0),(0,0),(0,0),(1,1).
REQ-037 SHALL pass this mid-word reset test: RESET pulsed low during beat 4 of 0xC1 -> outputs reach reset values immediately; after release SERIAL_VALID=0 until a new transfer occurs.
